// File: rtl/move_special_seq.sv
// Fetch + move-from-special-register sequencer: T0..T3 strobes, MemReady wait in T1, Done/Illegal status.
// Optional build macro MFS_TIMEOUT_EN bounds the T1 wait to WAIT_MAX cycles and reports a timeout as Illegal.
module move_special_seq #(
    parameter int                   IR_W     = 32,
    parameter int                   OPC_W    = 5,
    parameter logic [OPC_W-1:0]     OPC_BASE = 5'b11001,
    parameter int                   N_SRC    = 2,
    parameter int                   WAIT_MAX = 15
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic [IR_W-1:0]  IR,
    input  logic             MemReady,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Rin,
    output logic [N_SRC-1:0] SRCout,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_DONE,
        S_ILL
    } state_t;

    localparam logic [OPC_W:0] NSRC_L = (OPC_W+1)'(N_SRC);

    state_t           state;
    logic [OPC_W-1:0] opc;
    logic [OPC_W-1:0] src_idx;
    logic             legal;
    logic             in_t3;
    logic             unused_ir_bits;

    // IR is only meaningful once T2 has loaded it, so the T3 decode looks at it live
    assign opc            = IR[IR_W-1 -: OPC_W];
    assign src_idx        = opc - OPC_BASE;
    assign legal          = ({1'b0, src_idx} < NSRC_L);
    assign in_t3          = (state == S_T3);
    assign unused_ir_bits = ^IR[IR_W-OPC_W-1:0];

    // PCin marks only the T1 cycle in which memory reports ready, i.e. the exit cycle
    assign PCin = (state == S_T1) & MemReady;
    assign Gra  = in_t3 & legal;
    assign Rin  = in_t3 & legal;

    always_comb begin
        SRCout = '0;
        for (int i = 0; i < N_SRC; i++) begin
            SRCout[i] = in_t3 && legal && (src_idx == OPC_W'(i));
        end
    end

`ifdef MFS_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
    logic [7:0] wait_cnt;
`else
    localparam int unused_wait_max = WAIT_MAX;
`endif

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state   <= S_IDLE;
            PCout   <= 1'b0;
            MARin   <= 1'b0;
            IncPC   <= 1'b0;
            Zin     <= 1'b0;
            Zlowout <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            IRin    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Illegal <= 1'b0;
`ifdef MFS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            PCout   <= 1'b0;
            MARin   <= 1'b0;
            IncPC   <= 1'b0;
            Zin     <= 1'b0;
            Zlowout <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            IRin    <= 1'b0;
            Busy    <= 1'b1;
            Done    <= 1'b0;
            Illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state <= S_T0;
                        PCout <= 1'b1;
                        MARin <= 1'b1;
                        IncPC <= 1'b1;
                        Zin   <= 1'b1;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                S_T0: begin
                    state   <= S_T1;
                    Zlowout <= 1'b1;
                    Read    <= 1'b1;
                    MDRin   <= 1'b1;
`ifdef MFS_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_T1: begin
                    if (MemReady) begin
                        state  <= S_T2;
                        MDRout <= 1'b1;
                        IRin   <= 1'b1;
`ifdef MFS_TIMEOUT_EN
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= S_ILL;
                        Illegal <= 1'b1;
`endif
                    end else begin
                        Zlowout <= 1'b1;
                        Read    <= 1'b1;
                        MDRin   <= 1'b1;
`ifdef MFS_TIMEOUT_EN
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                S_T2: begin
                    state <= S_T3;
                end
                S_T3: begin
                    if (legal) begin
                        state <= S_DONE;
                        Done  <= 1'b1;
                    end else begin
                        state   <= S_ILL;
                        Illegal <= 1'b1;
                    end
                end
                default: begin
                    // DONE, ILL and any stray encoding fall back to IDLE; Start is ignored here
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_special_seq.sv
// Directed + randomized bench for move_special_seq against a phase-level model of the strobe table.
// Build with MFS_TIMEOUT_EN to exercise the bounded T1 wait instead of the unbounded one.
module tb_move_special_seq;

    localparam int N_SRC  = 2;
    localparam int WAIT_T = 4;
    localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4, P_DONE = 5, P_ILL = 6;

    logic             Clock = 1'b0;
    logic             Clear = 1'b0;
    logic             Start = 1'b0;
    logic [31:0]      IR = '0;
    logic             MemReady = 1'b0;
    logic             PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
    logic             MDRout, IRin, Gra, Rin, Busy, Done, Illegal;
    logic [N_SRC-1:0] SRCout;

    int compared   = 0;
    int mismatched = 0;

    move_special_seq #(
        .IR_W(32), .OPC_W(5), .OPC_BASE(5'b11001), .N_SRC(N_SRC), .WAIT_MAX(WAIT_T)
    ) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .IR(IR), .MemReady(MemReady),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rin(Rin), .SRCout(SRCout),
        .Busy(Busy), .Done(Done), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                    MDRout, IRin, Gra, Rin, SRCout, Busy, Done, Illegal});
    endfunction

    // Expected outputs for one cycle spent in a given phase, straight from the strobe table
    function automatic logic [31:0] model(input int ph, input logic mr, input logic [31:0] ir);
        logic [3:0]       t0s = '0, t1s = '0;
        logic [1:0]       t2s = '0, t3s = '0;
        logic [N_SRC-1:0] src = '0;
        logic             dn = 1'b0, il = 1'b0;
        int               op = int'(ir[31:27]);
        case (ph)
            P_T0:   t0s = 4'b1111;
            P_T1:   t1s = {1'b1, mr, 1'b1, 1'b1};
            P_T2:   t2s = 2'b11;
            P_T3:   if (op >= 25 && op <= 25 + N_SRC - 1) begin
                        t3s = 2'b11;
                        src = N_SRC'(1) << (op - 25);
                    end
            P_DONE: dn = 1'b1;
            P_ILL:  il = 1'b1;
            default: ;
        endcase
        return 32'({t0s, t1s, t2s, t3s, src, (ph != P_IDLE), dn, il});
    endfunction

    function automatic logic is_legal(input logic [31:0] ir);
        return (int'(ir[31:27]) >= 25) && (int'(ir[31:27]) <= 25 + N_SRC - 1);
    endfunction

    // One clock: inputs applied just after the edge, outputs checked mid-cycle
    task automatic step(input logic st, input logic mr, input logic [31:0] ir,
                        input int ph, input string tag);
        @(posedge Clock);
        #1;
        Start    = st;
        MemReady = mr;
        IR       = ir;
        #3;
        check(tag, outs(), model(ph, mr, ir));
    endtask

    task automatic run_seq(input logic [31:0] ir, input int waits, input string tag);
        step(1'b1, 1'($urandom), $urandom, P_IDLE, {tag, "_idle"});
        step(1'($urandom), 1'($urandom), $urandom, P_T0, {tag, "_t0"});
        for (int j = 0; j <= waits; j++)
            step(1'($urandom), (j == waits), $urandom, P_T1, {tag, "_t1"});
        step(1'($urandom), 1'($urandom), $urandom, P_T2, {tag, "_t2"});
        step(1'($urandom), 1'($urandom), ir, P_T3, {tag, "_t3"});
        step(1'($urandom), 1'($urandom), $urandom, is_legal(ir) ? P_DONE : P_ILL, {tag, "_end"});
        step(1'b0, 1'($urandom), $urandom, P_IDLE, {tag, "_back"});
    endtask

    initial begin
        // Reset held: everything quiet even while the clock runs
        repeat (2) @(posedge Clock);
        #4;
        check("reset_outs", outs(), 32'h0);
        @(negedge Clock);
        Clear = 1'b1;
        for (int k = 0; k < 10; k++)
            step(1'b0, 1'($urandom), $urandom, P_IDLE, "idle_quiet");

        run_seq(32'hC800_0000, 0, "hi_min");
        run_seq(32'hD000_0000, 3, "lo_wait3");
        run_seq(32'h0000_0000, 1, "opc_zero");
        run_seq(32'hD800_0000, 0, "opc_above");
        run_seq(32'hC000_0000, 2, "opc_below");

        // Clear pulled mid-sequence in T2
        step(1'b1, 1'b1, $urandom, P_IDLE, "clr_idle");
        step(1'b0, 1'b1, $urandom, P_T0, "clr_t0");
        step(1'b0, 1'b1, $urandom, P_T1, "clr_t1");
        step(1'b0, 1'b1, $urandom, P_T2, "clr_t2");
        Clear = 1'b0;
        #1;
        check("clr_async", outs(), 32'h0);
        @(posedge Clock);
        #2;
        check("clr_held", outs(), 32'h0);
        @(negedge Clock);
        Clear = 1'b1;
        run_seq(32'hCABC_1234, 1, "after_clr");

        for (int n = 0; n < 20; n++) begin
            logic [31:0] r = $urandom;
            r[31:27] = 5'($urandom_range(23, 28));
            run_seq(r, int'($urandom_range(0, 3)), "rand");
        end

        // Memory never ready
        step(1'b1, 1'b0, $urandom, P_IDLE, "stall_idle");
        step(1'b0, 1'b0, $urandom, P_T0, "stall_t0");
`ifdef MFS_TIMEOUT_EN
        for (int j = 0; j < WAIT_T; j++)
            step(1'($urandom), 1'b0, $urandom, P_T1, "stall_t1");
        step(1'b0, 1'b0, $urandom, P_ILL, "stall_timeout");
        step(1'b0, 1'b0, $urandom, P_IDLE, "stall_back");
`else
        for (int j = 0; j < 50; j++)
            step(1'($urandom), 1'b0, $urandom, P_T1, "stall_t1");
        step(1'b0, 1'b1, $urandom, P_T1, "stall_release");
        step(1'b0, 1'b0, $urandom, P_T2, "stall_t2");
        step(1'b0, 1'b0, 32'hC800_0000, P_T3, "stall_t3");
        step(1'b0, 1'b0, $urandom, P_DONE, "stall_done");
        step(1'b0, 1'b0, $urandom, P_IDLE, "stall_back");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
